// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Watches a multiplexed, active-low seven-segment bus (seg + an) and rebuilds
// the hex nibble shown on each digit. A digit is captured once its {an, seg}
// sample has been stable for STABLE_CYCLES consecutive samples.
// Optional build macro: SEG7_READER_STICKY_ERR_EN makes pat_err sticky until
// reset and adds the err_any output (OR of pat_err).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no qualified (one-hot-low an) sample being tracked
// COUNT   | qualified sample seen, counting identical repeats
// HELD    | current sample already captured, wait for it to change
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pat_err,
  output logic                    capture_pulse,
`ifdef SEG7_READER_STICKY_ERR_EN
  output logic                    err_any,
`endif
  output logic [2:0]              capture_idx
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0] an_s, an_p;
  logic [6:0]            seg_s, seg_p;
  logic [1:0]            state;
  logic [7:0]            cnt;

  logic       changed;
  logic       qual;
  logic [3:0] low_cnt;
  logic [2:0] idx;
  logic       hit;
  logic [3:0] nib;
  logic       blank;
  logic       cap_now;

  // Input stage: current sample plus the one before it for change detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_s  <= '1;
      seg_s <= 7'h7F;
      an_p  <= '1;
      seg_p <= 7'h7F;
    end else begin
      an_s  <= an;
      seg_s <= seg;
      an_p  <= an_s;
      seg_p <= seg_s;
    end
  end

  // Qualification: exactly one digit select low; remember which one.
  always_comb begin
    low_cnt = 4'd0;
    idx     = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) begin
        low_cnt = low_cnt + 4'd1;
        idx     = i[2:0];
      end
    end
    qual    = (low_cnt == 4'd1);
    changed = (an_s != an_p) || (seg_s != seg_p);
  end

  // Reverse segment map; anything outside the 16 glyphs is a miss.
  always_comb begin
    hit = 1'b1;
    nib = 4'h0;
    case (seg_s)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0001100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      default:    hit = 1'b0;
    endcase
    blank = (seg_s == 7'h7F);
  end

  // The last repeat that brings the count to STABLE_CYCLES is the capture.
  assign cap_now = (state == ST_COUNT) && !changed && (cnt == CNT_LAST);

  // Stability FSM; count saturates because HELD never increments it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (qual) begin
            state <= ST_COUNT;
            cnt   <= 8'd1;
          end
        end
        ST_COUNT: begin
          if (changed) begin
            state <= qual ? ST_COUNT : ST_IDLE;
            cnt   <= qual ? 8'd1 : 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
            if (cap_now) state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (changed) begin
            state <= qual ? ST_COUNT : ST_IDLE;
            cnt   <= qual ? 8'd1 : 8'd0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Per-digit result registers and capture strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hex_out       <= '0;
      digit_valid   <= '0;
      pat_err       <= '0;
      capture_pulse <= 1'b0;
      capture_idx   <= 3'd0;
    end else begin
      capture_pulse <= cap_now;
      if (cap_now) capture_idx <= idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_now && (idx == i[2:0])) begin
          if (hit) begin
            hex_out[4*i +: 4] <= nib;
            digit_valid[i]    <= 1'b1;
`ifndef SEG7_READER_STICKY_ERR_EN
            pat_err[i]        <= 1'b0;
`endif
          end else if (blank) begin
            digit_valid[i]    <= 1'b0;
`ifndef SEG7_READER_STICKY_ERR_EN
            pat_err[i]        <= 1'b0;
`endif
          end else begin
            pat_err[i]        <= 1'b1;
          end
        end
      end
    end
  end

`ifdef SEG7_READER_STICKY_ERR_EN
  assign err_any = |pat_err;
`endif

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the team's hex-to-seven-segment decoder.
- Watches a multiplexed, active-low seven-segment display bus (segment lines plus digit-select lines) and rebuilds the hex nibble shown on each digit.
- Used for on-chip readback and self-check of display output, and as a bench monitor for the display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits, i.e. width of the digit-select bus (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a capture (2..255).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- seg  input  7  active-low segment pattern; bit6=a, bit5=b ... bit0=g.
- an  input  NUM_DIGITS  active-low digit select; bit i low means digit i is driven.
- hex_out  output  4*NUM_DIGITS  recovered nibbles; digit i is in bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  digit i holds a decoded hex value.
- pat_err  output  NUM_DIGITS  last capture on digit i was an unrecognised pattern.
- capture_pulse  output  1  one-cycle strobe per capture.
- capture_idx  output  3  digit index of the most recent capture.

Behaviour:
- Reset (rst_n low at a clock edge):
  - All outputs go to 0.
  - Stability counter goes to 0; the FSM goes to IDLE.
  - The input sample register loads seg=7'h7F and an=all-ones.
- Input stage: {an, seg} is registered every cycle into a sample register. All decisions use the registered copy and compare it against the previous sample.
- "Qualified" means exactly one bit of the sampled an is 0 (one-hot-low).
- FSM states:
  - IDLE: a qualified sample moves to COUNT with count=1.
  - COUNT:
    - Sample changes but is still qualified: count=1, stay in COUNT.
    - Sample becomes unqualified: go to IDLE.
    - Sample equals the previous one: count increments.
    - When count reaches STABLE_CYCLES: perform a capture and go to HELD.
  - HELD:
    - Sample equals the previous one: no further capture.
    - Any change: go to COUNT with count=1 if qualified, else IDLE.
- Capture, for selected digit d:
  - Exact reverse map of seg: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000.
  - Match: hex_out[d]=nibble, digit_valid[d]=1, pat_err[d]=0.
  - Blank (7'b1111111): digit_valid[d]=0, pat_err[d]=0, hex_out[d] unchanged.
  - Any other pattern: pat_err[d]=1, digit_valid[d] and hex_out[d] unchanged.
- Capture outputs: capture_pulse=1 for exactly one cycle; capture_idx=d, held until the next capture.
- Latency: if new {an, seg} is applied before edge 0 and held, hex_out, digit_valid, pat_err and capture_pulse update at edge STABLE_CYCLES. With STABLE_CYCLES=4 that is edge 4 (1 register stage + 4 samples − 1 comparison overlap).
- Boundary conditions:
  - Glitch shorter than STABLE_CYCLES: no capture; the count restarts.
  - an all-ones, or two or more bits low: no capture, digit registers unaffected.
  - Same pattern re-qualified after any change: captured again, producing a new pulse.
  - Count saturates at STABLE_CYCLES and never wraps.
  - Digits outside 0..NUM_DIGITS-1 do not exist; one-hot qualification prevents them.
- Reset mid-count: the capture is abandoned and no pulse is issued. After rst_n deasserts, a held qualified input needs the full STABLE_CYCLES again.

Optional Feature:
- SEG7_READER_STICKY_ERR_EN defined:
  - pat_err[d] is sticky: once set it is cleared only by reset.
  - A blank or valid capture does not clear it.
  - An extra output err_any (1 bit) is added, equal to the OR of pat_err.
- Not defined: pat_err is as described in Behaviour, and err_any is absent.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with an=4'b1110, seg=7'b0010010.
  - Outputs stay 0 throughout.
  - After release, capture_pulse at the 4th edge; hex_out[3:0]=2, digit_valid=4'b0001.
- Full scan: cycle an through 1110, 1101, 1011, 0111, 8 cycles each, with patterns for A, 7, 0, F.
  - Result: hex_out=16'hF07A, digit_valid=4'hF, 4 pulses, capture_idx=3 at the end.
- Glitch: digit 1 shows 5 for 8 cycles, then seg=7'b0000000 for 2 cycles, then back to 5.
  - No capture of 8; hex_out[7:4]=5.
  - Exactly one extra pulse after 5 returns and is stable.
- Illegal select: an=4'b1100 with seg=pattern 3 held for 20 cycles.
  - No pulse; all outputs unchanged.
- Error and blank, on digit 2:
  - Valid 9, then seg=7'b1010101: pat_err[2]=1, hex_out[11:8]=9, digit_valid[2]=1.
  - Then blank: digit_valid[2]=0 and pat_err[2]=0. With SEG7_READER_STICKY_ERR_EN, pat_err[2] and err_any stay 1 instead.
- Long hold: a qualified pattern held for 100 cycles gives exactly one capture_pulse. The count saturates with no wrap-around recapture.
